// File: rtl/generic_router_pkg.sv
// Shared constants and types for the generic_router drain path.
package generic_router_pkg;

  localparam int unsigned ROUTER_WORD_W     = 64;
  localparam int unsigned FIFO_READER_SLOTS = 3;
  localparam int unsigned SLOT_PTR_W        = 2;

  typedef logic [ROUTER_WORD_W-1:0] router_word_t;

  // Advance a slot pointer, wrapping after the last slot.
  function automatic logic [SLOT_PTR_W-1:0] slot_next(input logic [SLOT_PTR_W-1:0] p);
    return (p == SLOT_PTR_W'(FIFO_READER_SLOTS - 1)) ? '0 : p + SLOT_PTR_W'(1);
  endfunction

endpackage

// File: rtl/fifo_reader_buf.sv
// 3-entry circular prefetch storage: write at tail, read at head.
// With FIFO_READER_PARITY_EN each entry also keeps a parity bit taken at capture.
module fifo_reader_buf
  import generic_router_pkg::*;
#(
  parameter int unsigned WIDTH = ROUTER_WORD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_adv,
  output logic [WIDTH-1:0] rd_data
`ifdef FIFO_READER_PARITY_EN
  ,
  output logic             rd_parity
`endif
);

  logic [WIDTH-1:0]      mem_q [FIFO_READER_SLOTS];
  logic [WIDTH-1:0]      mem_d [FIFO_READER_SLOTS];
  logic [SLOT_PTR_W-1:0] head_q, head_d;
  logic [SLOT_PTR_W-1:0] tail_q, tail_d;
`ifdef FIFO_READER_PARITY_EN
  logic                  par_q [FIFO_READER_SLOTS];
  logic                  par_d [FIFO_READER_SLOTS];
`endif

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    mem_d  = mem_q;
`ifdef FIFO_READER_PARITY_EN
    par_d  = par_q;
`endif
    if (wr_en) begin
      mem_d[tail_q] = wr_data;
`ifdef FIFO_READER_PARITY_EN
      par_d[tail_q] = ^wr_data;
`endif
      tail_d = slot_next(tail_q);
    end
    if (rd_adv) begin
      head_d = slot_next(head_q);
    end
  end

  // Pointers reset; payload storage is intentionally left uncleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
`ifdef FIFO_READER_PARITY_EN
    par_q <= par_d;
`endif
  end

  assign rd_data = mem_q[head_q];
`ifdef FIFO_READER_PARITY_EN
  assign rd_parity = par_q[head_q];
`endif

endmodule

// File: rtl/fifo_reader_64.sv
// Drain side of the router FIFO: pops words, prefetches up to 3, streams them out.
// Optional FIFO_READER_PARITY_EN adds a registered even-parity output.
module fifo_reader_64
  import generic_router_pkg::*;
#(
  parameter int unsigned WIDTH = ROUTER_WORD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             empty,
  output logic             pop,
  input  logic [WIDTH-1:0] mem_rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef FIFO_READER_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int unsigned OCC_W  = 2;
  localparam int unsigned FILL_W = 3;

  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic [FILL_W-1:0] fill_c;
  logic              fire_c;

  assign out_valid = (occ_q != '0);
  assign busy      = (occ_q != '0) || inflight_q;

  // pop looks only at registered fill level and empty, never at out_ready.
  always_comb begin
    fill_c     = FILL_W'(occ_q) + FILL_W'(inflight_q);
    pop        = !reset && !empty && (fill_c < FILL_W'(FIFO_READER_SLOTS));
    fire_c     = out_valid && out_ready;
    inflight_d = pop;
    occ_d      = OCC_W'(fill_c - FILL_W'(fire_c));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
    end
  end

  fifo_reader_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (inflight_q),
    .wr_data   (mem_rd_data),
    .rd_adv    (fire_c),
    .rd_data   (out_data)
`ifdef FIFO_READER_PARITY_EN
    ,
    .rd_parity (out_parity)
`endif
  );

endmodule

// File: tb/tb_fifo_reader_64.sv
// Randomized self-checking bench for fifo_reader_64 against a queue-based model.
module tb_fifo_reader_64;
  import generic_router_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         empty;
  logic         pop;
  router_word_t mem_rd_data;
  logic         out_valid;
  logic         out_ready;
  router_word_t out_data;
  logic         busy;
`ifdef FIFO_READER_PARITY_EN
  logic         out_parity;
`endif

  fifo_reader_64 dut (
    .clk         (clk),
    .reset       (reset),
    .empty       (empty),
    .pop         (pop),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy)
`ifdef FIFO_READER_PARITY_EN
    ,
    .out_parity  (out_parity)
`endif
  );

  always #5 clk = ~clk;

  // Reference: source FIFO contents, prefetch contents, one in-flight word.
  router_word_t src[$];
  router_word_t bufq[$];
  bit           infl_m;
  router_word_t infl_w;
  bit           stall_en;

  int n_cmp;
  int n_err;
  int cyc;
  int obs_cyc;
  bit obs_pop, obs_valid, obs_fire;
  router_word_t obs_data;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic cycle(input bit rdy);
    bit exp_pop, exp_valid, exp_busy, do_fire;
    empty     = (src.size() == 0) || (stall_en && ($urandom_range(0, 3) == 0));
    out_ready = rdy;
    #1;
    exp_valid = (bufq.size() != 0);
    exp_pop   = !reset && !empty && ((bufq.size() + int'(infl_m)) < 3);
    exp_busy  = exp_valid || infl_m;
    check_eq("pop", 64'(pop), 64'(exp_pop));
    check_eq("out_valid", 64'(out_valid), 64'(exp_valid));
    check_eq("busy", 64'(busy), 64'(exp_busy));
    if (exp_valid) begin
      check_eq("out_data", out_data, bufq[0]);
`ifdef FIFO_READER_PARITY_EN
      check_eq("out_parity", 64'(out_parity), 64'(^bufq[0]));
`endif
    end
    obs_cyc   = cyc;
    obs_pop   = pop;
    obs_valid = out_valid;
    obs_data  = out_data;
    obs_fire  = out_valid && rdy;
    do_fire   = exp_valid && rdy;
    @(posedge clk);
    cyc++;
    if (reset) begin
      bufq.delete();
      src.delete();
      infl_m = 1'b0;
    end else begin
      if (do_fire) void'(bufq.pop_front());
      if (infl_m) bufq.push_back(infl_w);
      infl_m = exp_pop;
      if (exp_pop) infl_w = src.pop_front();
    end
    #1;
    mem_rd_data = infl_m ? infl_w : {$urandom, $urandom};
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && (src.size() != 0 || bufq.size() != 0 || infl_m); i++) cycle(1'b1);
    cycle(1'b1);
    check_eq(tag, 64'(busy), 64'd0);
  endtask

  initial begin
    int tp, tv, nf, first_f, last_f, npop;
    router_word_t vdata;
    n_cmp = 0; n_err = 0; cyc = 0;
    infl_m = 1'b0; infl_w = '0; stall_en = 1'b0;
    reset = 1'b1; empty = 1'b1; out_ready = 1'b0; mem_rd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset then idle.
    for (int i = 0; i < 10; i++) cycle(1'b0);

    // Single word latency.
    src.push_back(64'hDEAD_BEEF_0000_0001);
    tp = -1; tv = -1; vdata = '0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1);
      if (obs_pop && tp < 0) tp = obs_cyc;
      if (obs_valid && tv < 0) begin tv = obs_cyc; vdata = obs_data; end
    end
    check_eq("single_latency", 64'(tv - tp), 64'd2);
    check_eq("single_data", vdata, 64'hDEAD_BEEF_0000_0001);

    // Streaming 8 words at full rate.
    for (int i = 0; i < 8; i++) src.push_back(router_word_t'(i));
    nf = 0; first_f = -1; last_f = -1;
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1);
      if (obs_fire) begin
        check_eq("stream_order", obs_data, router_word_t'(nf));
        if (first_f < 0) first_f = obs_cyc;
        last_f = obs_cyc;
        nf++;
      end
    end
    check_eq("stream_fires", 64'(nf), 64'd8);
    check_eq("stream_span", 64'(last_f - first_f), 64'd7);

    // Backpressure: only three pops while stalled, head word held.
    for (int i = 0; i < 8; i++) src.push_back(router_word_t'(i));
    npop = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0);
      if (obs_pop) npop++;
    end
    check_eq("bp_pops", 64'(npop), 64'd3);
    check_eq("bp_head_valid", 64'(obs_valid), 64'd1);
    check_eq("bp_head_data", obs_data, 64'd0);
    nf = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1);
      if (obs_fire) begin
        check_eq("bp_order", obs_data, router_word_t'(nf));
        nf++;
      end
    end
    check_eq("bp_fires", 64'(nf), 64'd8);

    // Alternating ready over 20 words exercises pointer wrap.
    for (int i = 0; i < 20; i++) src.push_back(router_word_t'(64'h100 + 64'(i)));
    nf = 0;
    for (int i = 0; i < 70; i++) begin
      cycle(i[0]);
      if (obs_fire) begin
        check_eq("alt_order", obs_data, router_word_t'(64'h100 + 64'(nf)));
        nf++;
      end
    end
    check_eq("alt_fires", 64'(nf), 64'd20);

    // Random traffic with source stalls and downstream backpressure.
    stall_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) src.push_back({$urandom, $urandom});
      cycle(1'($urandom_range(0, 2) != 0));
    end
    stall_en = 1'b0;
    drain("rand_drain_idle");

    // Mid-run reset with two buffered words and one in flight.
    for (int i = 0; i < 8; i++) src.push_back({$urandom, $urandom});
    for (int i = 0; i < 3; i++) cycle(1'b0);
    check_eq("pre_rst_busy", 64'(obs_valid), 64'd1);
    reset = 1'b1;
    cycle(1'b0);
    reset = 1'b0;
    cycle(1'b0);
    check_eq("rst_valid", 64'(obs_valid), 64'd0);
    check_eq("rst_pop", 64'(obs_pop), 64'd0);

    // Restart after reset.
    src.push_back(64'hCAFE_0000_0000_00AA);
    drain("post_rst_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_reader_64.md
# fifo_reader_64

Drain-side companion to the generic_router 8x64 FIFO: issues `pop` to the FIFO, captures `mem_rd_data` one cycle later, and presents words on a valid/ready output stream toward the router output port. A 3-entry prefetch buffer hides the memory read latency. It sustains one word per cycle with no combinational path from `out_ready` to `pop`.

## Interface
- `WIDTH`, 64, data word width; must match the FIFO memory width.
- `clk` input 1, single clock; all logic rising-edge.
- `reset` input 1, synchronous, active-high; clears all state.
- `empty` input 1, FIFO empty flag from fifo_ctrl.
- `pop` output 1, pop request to fifo_ctrl.
- `mem_rd_data` input WIDTH, FIFO memory read data; valid the cycle after `pop`.
- `out_valid` output 1, head of buffer holds a word.
- `out_ready` input 1, downstream accepts this cycle.
- `out_data` output WIDTH, head word; stable while `out_valid && !out_ready`.
- `busy` output 1, `occ != 0 || inflight`.
- `out_parity` output 1, even parity of `out_data`; present only with `FIFO_READER_PARITY_EN`.

## Operation
- State: `occ` (0..3, buffered words), `inflight` (1 = pop issued last cycle), 3-entry circular buffer with `head`/`tail` pointers (mod 3).
- `pop = !reset && !empty && (occ + inflight) < 3`. This depends only on registered state and `empty`, never on `out_ready`.
- `inflight <= pop` each cycle.
- If `inflight`, `mem_rd_data` is written at `tail`, and `tail` advances, wrapping 2->0.
- Fire = `out_valid && out_ready`; on fire, `head` advances, wrapping 2->0.
- `occ <= occ + inflight - fire`. A simultaneous capture and fire leaves `occ` unchanged.
- `out_valid = (occ != 0)`; `out_data = buf[head]`.
- Width rules:
  - `occ` is 2 bits.
  - `occ + inflight` is evaluated in 3 bits.
  - The sum never exceeds 3 by construction.
- Overflow is impossible: a capture is only pending when `occ + inflight < 3` held at pop time.
- Underflow is impossible: fire requires `occ != 0`.

## Timing
- Reset values: `pop` = 0, `out_valid` = 0, `busy` = 0, `occ` = 0, `inflight` = 0, `head` = 0, `tail` = 0. `out_data` is undefined (buffer is not cleared). `out_parity` follows `out_data`.
- Latency, empty buffer: `empty` falls at cycle T -> `pop` at T -> capture at T+1 edge -> `out_valid` at T+2.
- Throughput: one word per cycle while `!empty` and `out_ready` is held high.
- Backpressure: with `out_ready` low, at most 3 words are popped (including the one in flight), then `pop` stays 0.
- Handshake rules:
  - `out_valid` never deasserts without a fire.
  - `out_data` is stable until fire.
- FIFO going empty: `pop` drops in the same cycle as `empty`. An in-flight word is still captured.
- Reset mid-operation: any in-flight word is discarded and the buffer is emptied. fifo_ctrl shares `reset`, so the system restarts consistently.

## Configuration
- `FIFO_READER_PARITY_EN` defined:
  - Adds the `out_parity` output.
  - Each buffer entry stores a parity bit computed at capture, so the parity is registered and aligned with `out_data`.
- `FIFO_READER_PARITY_EN` undefined: no `out_parity` port and no parity storage. All other behaviour is identical.

## Structure
- Shared package `generic_router_pkg` holds:
  - `ROUTER_WORD_W = 64`.
  - `FIFO_READER_SLOTS = 3`.
  - Typedef `router_word_t` (logic [ROUTER_WORD_W-1:0]).
- Sub-module `fifo_reader_buf`: 3-entry circular storage with write-at-tail and read-at-head, plus pointer wrap logic. The top level owns `occ`, `inflight` and `pop`.

## Test plan
- Reset then idle: `empty` = 1 for 10 cycles -> `pop` = 0, `out_valid` = 0, `busy` = 0 throughout.
- Single word: FIFO holds 0xDEAD_BEEF_0000_0001, `out_ready` = 1 -> `pop` at T, `out_valid` at T+2 with that data, fire, then `out_valid` = 0.
- Streaming: 8 words 0x0..0x7, `out_ready` = 1 -> 8 consecutive fires, in order, one per cycle after the 2-cycle startup.
- Backpressure: 8 words queued, `out_ready` = 0 for 6 cycles -> exactly 3 pops, `out_valid` = 1 with word 0x0 held stable. Releasing `out_ready` drains 0x0..0x7 in order.
- Wrap and simultaneity: alternate `out_ready` 1/0 over 20 words -> pointers wrap 2->0 repeatedly, no loss or duplication, and `occ` never exceeds 3.
- Mid-run reset: assert `reset` for 1 cycle with `occ` = 2 and `inflight` = 1 -> the next cycle shows `out_valid` = 0 and `pop` = 0. With `FIFO_READER_PARITY_EN`, check `out_parity` = ^`out_data` on every fire.
